// File: rtl/ptw_pkg.sv
// Shared types and constants for the Sv32 page-table walker: FSM states,
// request/privilege encodings and PTE field positions.
package ptw_pkg;

  localparam int XLEN       = 32;
  localparam int PAGE_SHIFT = 12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_L1   = 2'd1,
    S_L0   = 2'd2,
    S_DONE = 2'd3
  } ptw_state_e;

  // Access type; 2'b11 is handled like a load.
  localparam logic [1:0] TYPE_LOAD  = 2'b00;
  localparam logic [1:0] TYPE_STORE = 2'b01;
  localparam logic [1:0] TYPE_FETCH = 2'b10;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_U       = 4;
  localparam int PTE_G       = 5;
  localparam int PTE_A       = 6;
  localparam int PTE_D       = 7;
  localparam int PTE_PPN0_LO = 10;
  localparam int PTE_PPN0_HI = 19;
  localparam int PTE_PPN1_LO = 20;
  localparam int PTE_PPN1_HI = 31;

endpackage

// File: rtl/sv32_pte_check.sv
// Combinational Sv32 PTE classifier shared by both walk levels.
// Define SV32_PTW_AD_CHECK_EN to fault on leaves with A=0 or stores to D=0 pages.
module sv32_pte_check
  import ptw_pkg::*;
(
  input  logic [XLEN-1:0] i_pte,
  input  logic [1:0]      i_req_type,
  input  logic [1:0]      i_priv,
  input  logic            i_level,
  output logic            o_leaf,
  output logic            o_fault,
  output logic            o_misaligned
);

  logic w_bad_enc;
  logic w_type_fail;
  logic w_priv_fail;
  logic w_ad_fail;
  logic w_unused;

  assign w_bad_enc    = ~i_pte[PTE_V] | (~i_pte[PTE_R] & i_pte[PTE_W]);
  assign o_leaf       = i_pte[PTE_R] | i_pte[PTE_X];
  assign o_misaligned = i_level & o_leaf & (i_pte[PTE_PPN0_HI:PTE_PPN0_LO] != 10'd0);

  // Access-type permission: the required R/W/X bit must be set.
  always_comb begin
    w_type_fail = 1'b0;
    case (i_req_type)
      TYPE_LOAD:  w_type_fail = ~i_pte[PTE_R];
      TYPE_STORE: w_type_fail = ~i_pte[PTE_W];
      TYPE_FETCH: w_type_fail = ~i_pte[PTE_X];
      default:    w_type_fail = ~i_pte[PTE_R];
    endcase
  end

  // Privilege permission: U-mode needs U=1, S-mode needs U=0.
  always_comb begin
    w_priv_fail = 1'b0;
    case (i_priv)
      PRIV_U:  w_priv_fail = ~i_pte[PTE_U];
      PRIV_S:  w_priv_fail = i_pte[PTE_U];
      default: w_priv_fail = 1'b0;
    endcase
  end

`ifdef SV32_PTW_AD_CHECK_EN
  assign w_ad_fail = ~i_pte[PTE_A] | ((i_req_type == TYPE_STORE) & ~i_pte[PTE_D]);
  assign w_unused  = ^{i_pte[PTE_PPN1_HI:PTE_PPN1_LO], i_pte[9:8], i_pte[PTE_G]};
`else
  assign w_ad_fail = 1'b0;
  assign w_unused  = ^{i_pte[PTE_PPN1_HI:PTE_PPN1_LO], i_pte[9:8], i_pte[PTE_G],
                       i_pte[PTE_A], i_pte[PTE_D]};
`endif

  // A non-leaf is only legal as a level-1 pointer.
  assign o_fault = w_bad_enc
                 | (~i_level & ~o_leaf)
                 | (o_leaf & (w_type_fail | w_priv_fail | w_ad_fail | o_misaligned));

endmodule

// File: rtl/sv32_ptw.sv
// Sv32 hardware page-table walker: L1 PTE on dmem port 1, L0 PTE on port 2.
// Optional A/D enforcement under SV32_PTW_AD_CHECK_EN (inside sv32_pte_check).
module sv32_ptw
  import ptw_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_vaddr,
  input  logic [1:0]      req_type,
  input  logic [1:0]      req_priv,
  input  logic [XLEN-1:0] satp,
  input  logic            flush,
  input  logic            dmem_busy,
  output logic [XLEN-1:0] pt_addr1,
  input  logic [XLEN-1:0] pt_rdata1,
  output logic [XLEN-1:0] pt_addr2,
  input  logic [XLEN-1:0] pt_rdata2,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_paddr,
  output logic            resp_fault,
  output logic            resp_mega
);

  ptw_state_e r_state;
  ptw_state_e w_next_state;

  logic [21:0]     r_vaddr;
  logic [1:0]      r_type;
  logic [1:0]      r_priv;
  logic [XLEN-1:0] r_pt_addr1;
  logic [XLEN-1:0] r_pt_addr2;
  logic            r_req_ready;
  logic            r_resp_valid;
  logic [XLEN-1:0] r_resp_paddr;
  logic            r_resp_fault;
  logic            r_resp_mega;

  logic            w_accept;
  logic            w_to_l0;
  logic            w_rsp_load;
  logic [XLEN-1:0] w_rsp_paddr;
  logic            w_rsp_fault;
  logic            w_rsp_mega;

  logic [XLEN-1:0] w_chk_pte;
  logic            w_chk_level;
  logic            w_chk_leaf;
  logic            w_chk_fault;
  logic            w_chk_misaligned;

  logic [XLEN-1:0] w_l1_addr;
  logic [XLEN-1:0] w_l0_addr;
  logic [XLEN-1:0] w_mega_paddr;
  logic [XLEN-1:0] w_page_paddr;
  logic            w_unused;

  // Address concatenations keep only the low 32 bits of the 34-bit results.
  assign w_l1_addr    = {satp[19:0], req_vaddr[31:22], 2'b00};
  assign w_l0_addr    = {pt_rdata1[29:10], r_vaddr[21:12], 2'b00};
  assign w_mega_paddr = {pt_rdata1[29:20], r_vaddr[21:0]};
  assign w_page_paddr = {pt_rdata2[29:10], r_vaddr[PAGE_SHIFT-1:0]};

  assign w_chk_level = (r_state == S_L1);
  assign w_chk_pte   = w_chk_level ? pt_rdata1 : pt_rdata2;
  assign w_unused    = ^{satp[30:20], w_chk_misaligned};

  sv32_pte_check u_pte_check (
    .i_pte        (w_chk_pte),
    .i_req_type   (r_type),
    .i_priv       (r_priv),
    .i_level      (w_chk_level),
    .o_leaf       (w_chk_leaf),
    .o_fault      (w_chk_fault),
    .o_misaligned (w_chk_misaligned)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and response payload; flush overrides everything, including accept.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_to_l0      = 1'b0;
    w_rsp_load   = 1'b0;
    w_rsp_paddr  = 32'd0;
    w_rsp_fault  = 1'b0;
    w_rsp_mega   = 1'b0;
    if (flush) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            w_accept = 1'b1;
            if (!satp[31] || (req_priv == PRIV_M)) begin
              w_next_state = S_DONE;
              w_rsp_load   = 1'b1;
              w_rsp_paddr  = req_vaddr;
            end else begin
              w_next_state = S_L1;
            end
          end else begin
            w_next_state = S_IDLE;
          end
        end
        S_L1: begin
          if (dmem_busy) begin
            w_next_state = S_L1;
          end else if (w_chk_fault) begin
            w_next_state = S_DONE;
            w_rsp_load   = 1'b1;
            w_rsp_fault  = 1'b1;
          end else if (w_chk_leaf) begin
            w_next_state = S_DONE;
            w_rsp_load   = 1'b1;
            w_rsp_paddr  = w_mega_paddr;
            w_rsp_mega   = 1'b1;
          end else begin
            w_next_state = S_L0;
            w_to_l0      = 1'b1;
          end
        end
        S_L0: begin
          if (dmem_busy) begin
            w_next_state = S_L0;
          end else begin
            w_next_state = S_DONE;
            w_rsp_load   = 1'b1;
            if (w_chk_fault) begin
              w_rsp_fault = 1'b1;
            end else begin
              w_rsp_paddr = w_page_paddr;
            end
          end
        end
        S_DONE:  w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Request context and PTE addresses, captured when each level is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vaddr    <= 22'd0;
      r_type     <= 2'd0;
      r_priv     <= 2'd0;
      r_pt_addr1 <= 32'd0;
      r_pt_addr2 <= 32'd0;
    end else begin
      if (w_accept) begin
        r_vaddr    <= req_vaddr[21:0];
        r_type     <= req_type;
        r_priv     <= req_priv;
        r_pt_addr1 <= w_l1_addr;
      end
      if (w_to_l0) begin
        r_pt_addr2 <= w_l0_addr;
      end
    end
  end

  // Response registers: valid pulses in DONE, payload holds until the next DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_paddr <= 32'd0;
      r_resp_fault <= 1'b0;
      r_resp_mega  <= 1'b0;
    end else begin
      r_req_ready  <= (w_next_state == S_IDLE);
      r_resp_valid <= w_rsp_load;
      if (w_rsp_load) begin
        r_resp_paddr <= w_rsp_paddr;
        r_resp_fault <= w_rsp_fault;
        r_resp_mega  <= w_rsp_mega;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign pt_addr1   = r_pt_addr1;
  assign pt_addr2   = r_pt_addr2;
  assign resp_valid = r_resp_valid;
  assign resp_paddr = r_resp_paddr;
  assign resp_fault = r_resp_fault;
  assign resp_mega  = r_resp_mega;

endmodule

// File: tb/tb_sv32_ptw.sv
// Randomized self-checking bench for sv32_ptw against an arithmetic Sv32 walk model.
module tb_sv32_ptw;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic [1:0]  req_type;
  logic [1:0]  req_priv;
  logic [31:0] satp;
  logic        flush;
  logic        dmem_busy;
  logic [31:0] pt_addr1;
  logic [31:0] pt_rdata1;
  logic [31:0] pt_addr2;
  logic [31:0] pt_rdata2;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic        resp_fault;
  logic        resp_mega;

  logic [31:0] mem [0:4095];
  int n_cmp = 0;
  int n_err = 0;

  sv32_ptw dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_vaddr  (req_vaddr),
    .req_type   (req_type),
    .req_priv   (req_priv),
    .satp       (satp),
    .flush      (flush),
    .dmem_busy  (dmem_busy),
    .pt_addr1   (pt_addr1),
    .pt_rdata1  (pt_rdata1),
    .pt_addr2   (pt_addr2),
    .pt_rdata2  (pt_rdata2),
    .resp_valid (resp_valid),
    .resp_paddr (resp_paddr),
    .resp_fault (resp_fault),
    .resp_mega  (resp_mega)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16 KiB combinational page-table memory; anything above reads as zero.
  assign pt_rdata1 = (pt_addr1 < 32'd16384) ? mem[pt_addr1[13:2]] : 32'd0;
  assign pt_rdata2 = (pt_addr2 < 32'd16384) ? mem[pt_addr2[13:2]] : 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] val);
    mem[addr[13:2]] = val;
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a < 32'd16384) return mem[a[13:2]];
    return 32'd0;
  endfunction

  function automatic logic perm_ok(input logic [31:0] pte, input logic [1:0] ty, input logic [1:0] pv);
    logic ok;
    case (ty)
      2'b01:   ok = pte[2];
      2'b10:   ok = pte[3];
      default: ok = pte[1];
    endcase
    if (pv == 2'b00 && !pte[4]) ok = 1'b0;
    if (pv == 2'b01 && pte[4]) ok = 1'b0;
`ifdef SV32_PTW_AD_CHECK_EN
    if (!pte[6]) ok = 1'b0;
    if (ty == 2'b01 && !pte[7]) ok = 1'b0;
`endif
    return ok;
  endfunction

  // Spec-level walk: expected paddr/fault/mega, unstalled latency and L1 PTE address.
  function automatic void ref_walk(input logic [31:0] sv, input logic [31:0] va,
                                   input logic [1:0] ty, input logic [1:0] pv,
                                   output logic [31:0] pa, output logic flt, output logic mg,
                                   output int lat, output logic [31:0] a1);
    logic [63:0] addr;
    logic [31:0] pte;
    pa = 32'd0; flt = 1'b0; mg = 1'b0;
    addr = 64'(sv[21:0]) * 64'd4096 + 64'(va >> 22) * 64'd4;
    a1 = addr[31:0];
    if (!sv[31] || pv == 2'b11) begin
      pa = va; lat = 1;
      return;
    end
    lat = 2;
    pte = mem_rd(a1);
    for (int lvl = 1; lvl >= 0; lvl--) begin
      if (!pte[0] || (!pte[1] && pte[2])) begin flt = 1'b1; return; end
      if (pte[1] || pte[3]) begin
        if (!perm_ok(pte, ty, pv)) begin flt = 1'b1; return; end
        if (lvl == 1) begin
          if (((pte >> 10) & 32'h3FF) != 32'd0) begin flt = 1'b1; return; end
          addr = 64'(pte >> 20) * 64'h40_0000 + 64'(va & 32'h3F_FFFF);
          pa = addr[31:0]; mg = 1'b1;
          return;
        end
        addr = 64'(pte >> 10) * 64'd4096 + 64'(va & 32'hFFF);
        pa = addr[31:0];
        return;
      end
      if (lvl == 0) begin flt = 1'b1; return; end
      addr = 64'(pte >> 10) * 64'd4096 + 64'((va >> 12) & 32'h3FF) * 64'd4;
      pte = mem_rd(addr[31:0]);
      lat = 3;
    end
  endfunction

  // One request with `busy` dmem_busy cycles at the start of L1.
  task automatic run_walk(input string tag, input logic [31:0] sv, input logic [31:0] va,
                          input logic [1:0] ty, input logic [1:0] pv, input int busy);
    logic [31:0] e_pa, e_a1;
    logic        e_flt, e_mg;
    int          e_lat, lat;
    bit          bare;
    ref_walk(sv, va, ty, pv, e_pa, e_flt, e_mg, e_lat, e_a1);
    bare = (e_lat == 1);
    if (!bare) e_lat += busy;
    @(negedge clk);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_vaddr = va; req_type = ty; req_priv = pv; satp = sv;
    @(posedge clk); #1;
    req_valid = 1'b0; satp = $urandom(); req_vaddr = $urandom();
    lat = 1;
    dmem_busy = (busy >= 1);
    while (1) begin
      if (!bare && lat <= busy + 1) check_eq({tag, "_pt_addr1"}, pt_addr1, e_a1);
      if (resp_valid || lat >= 20) break;
      @(posedge clk); #1;
      lat++;
      dmem_busy = (lat <= busy);
    end
    dmem_busy = 1'b0;
    check_eq({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check_eq({tag, "_lat"}, 32'(lat), 32'(e_lat));
    check_eq({tag, "_paddr"}, resp_paddr, e_pa);
    check_eq({tag, "_fault"}, 32'(resp_fault), 32'(e_flt));
    check_eq({tag, "_mega"}, 32'(resp_mega), 32'(e_mg));
    @(posedge clk); #1;
    check_eq({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_hold"}, resp_paddr, e_pa);
  endtask

  task automatic count_resp(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (resp_valid) seen++;
      @(posedge clk); #1;
    end
    check_eq(tag, 32'(seen), 32'd0);
  endtask

  localparam logic [31:0] SV_ON = 32'h8000_0001;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_vaddr = 32'd0; req_type = 2'd0; req_priv = 2'd0;
    satp = 32'd0; flush = 1'b0; dmem_busy = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_paddr", resp_paddr, 32'd0);
    check_eq("rst_fault", 32'(resp_fault), 32'd0);
    check_eq("rst_mega", 32'(resp_mega), 32'd0);
    check_eq("rst_addr1", pt_addr1, 32'd0);
    check_eq("rst_addr2", pt_addr2, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_walk("bare", 32'h0, 32'h0000_1234, 2'b00, 2'b01, 0);
    put(32'h1004, 32'h0000_0801); put(32'h2008, 32'h0000_14C7);
    run_walk("walk", SV_ON, 32'h0040_2ABC, 2'b01, 2'b01, 0);
    run_walk("mmode", SV_ON, 32'h0040_2ABC, 2'b00, 2'b11, 0);
    run_walk("busy", SV_ON, 32'h0040_2ABC, 2'b01, 2'b01, 2);
    put(32'h2008, 32'h0000_0C01);
    run_walk("l0_ptr", SV_ON, 32'h0040_2ABC, 2'b00, 2'b01, 0);
    put(32'h2008, 32'h0000_14C9);
    run_walk("xonly_ld", SV_ON, 32'h0040_2ABC, 2'b00, 2'b01, 0);
    run_walk("xonly_fx", SV_ON, 32'h0040_2ABC, 2'b10, 2'b01, 0);
    put(32'h2008, 32'h0000_14C7);
    run_walk("u_on_s", SV_ON, 32'h0040_2ABC, 2'b00, 2'b00, 0);
    put(32'h2008, 32'h0000_14D7);
    run_walk("u_on_u", SV_ON, 32'h0040_2ABC, 2'b00, 2'b00, 0);
    run_walk("s_on_u", SV_ON, 32'h0040_2ABC, 2'b00, 2'b01, 0);
    put(32'h2008, 32'h0000_1447);
    run_walk("d0_st", SV_ON, 32'h0040_2ABC, 2'b01, 2'b01, 0);
    put(32'h2008, 32'h0000_1407);
    run_walk("a0_ld", SV_ON, 32'h0040_2ABC, 2'b11, 2'b01, 0);

    put(32'h1000, 32'h0040_00CF);
    run_walk("mega", SV_ON, 32'h0012_3456, 2'b10, 2'b01, 0);
    put(32'h1000, 32'h0040_04CF);
    run_walk("misalign", SV_ON, 32'h0012_3456, 2'b10, 2'b01, 0);
    put(32'h1000, 32'h0000_00CE);
    run_walk("l1_inval", SV_ON, 32'h0012_3456, 2'b00, 2'b01, 0);
    put(32'h1000, 32'h0000_00C5);
    run_walk("l1_w_nr", SV_ON, 32'h0012_3456, 2'b01, 2'b01, 0);

    // flush while in L0
    put(32'h2008, 32'h0000_14C7);
    @(negedge clk);
    req_valid = 1'b1; satp = SV_ON; req_vaddr = 32'h0040_2ABC; req_type = 2'b01; req_priv = 2'b01;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check_eq("flush_ready", 32'(req_ready), 32'd1);
    count_resp("flush_noresp", 5);
    run_walk("after_flush", SV_ON, 32'h0040_2ABC, 2'b01, 2'b01, 0);

    // reset while in L1
    @(negedge clk);
    req_valid = 1'b1; satp = SV_ON; req_vaddr = 32'h0040_2ABC; req_type = 2'b00; req_priv = 2'b01;
    @(posedge clk); #1; req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check_eq("mrst_ready", 32'(req_ready), 32'd1);
    check_eq("mrst_paddr", resp_paddr, 32'd0);
    check_eq("mrst_addr1", pt_addr1, 32'd0);
    check_eq("mrst_addr2", pt_addr2, 32'd0);
    count_resp("mrst_noresp", 5);
    run_walk("after_rst", SV_ON, 32'h0040_2ABC, 2'b01, 2'b01, 1);

    // flush in IDLE blocks the accept
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; satp = 32'h0; req_vaddr = 32'h0000_0ABC; req_priv = 2'b01;
    @(posedge clk); #1; req_valid = 1'b0; flush = 1'b0;
    check_eq("idleflush_ready", 32'(req_ready), 32'd1);
    count_resp("idleflush_noresp", 3);

    for (int t = 0; t < 60; t++) begin
      logic [31:0] sv, va, p1, p2;
      logic [63:0] a;
      logic [1:0]  ty, pv;
      int          pick;
      clear_mem();
      sv = $urandom();
      sv[21:0] = 22'($urandom_range(1, 3));
      sv[31] = ($urandom_range(0, 7) != 0);
      va = $urandom();
      p1 = $urandom();
      pick = $urandom_range(0, 2);
      if (pick == 0) begin
        p1[31:10] = 22'($urandom_range(0, 3));
        p1[3:1] = 3'b000;
      end else if (pick == 1) begin
        p1[19:10] = 10'd0;
      end
      if ($urandom_range(0, 4) != 0) p1[0] = 1'b1;
      if ($urandom_range(0, 3) != 0) p1[7:6] = 2'b11;
      a = 64'(sv[21:0]) * 64'd4096 + 64'(va >> 22) * 64'd4;
      put(a[31:0], p1);
      p2 = $urandom();
      if ($urandom_range(0, 3) != 0) p2[0] = 1'b1;
      if ($urandom_range(0, 3) != 0) p2[7:6] = 2'b11;
      a = 64'(p1 >> 10) * 64'd4096 + 64'((va >> 12) & 32'h3FF) * 64'd4;
      if (a[31:0] < 32'd16384) put(a[31:0], p2);
      ty = 2'($urandom_range(0, 3));
      pick = $urandom_range(0, 2);
      pv = (pick == 2) ? 2'b11 : 2'(pick);
      run_walk("rnd", sv, va, ty, pv, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
